// File: rtl/suma_multinibble_pkg.sv
// Shared encodings for the nibble-serial adder: FSM states and slice width.
package suma_multinibble_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUMA = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/S4bits_instanciado.sv
// Combinational 4-bit ripple-carry adder; W[4] is the carry out.
module S4bits_instanciado
  import suma_multinibble_pkg::*;
(
  input  logic [NIB_W-1:0] X,
  input  logic [NIB_W-1:0] Y,
  input  logic             cin,
  output logic [NIB_W:0]   W
);

  logic [NIB_W:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign W[i]     = X[i] ^ Y[i] ^ w_c[i];
    assign w_c[i+1] = (X[i] & Y[i]) | (w_c[i] & (X[i] ^ Y[i]));
  end

  assign W[NIB_W] = w_c[NIB_W];

endmodule

// File: rtl/suma_multinibble.sv
// Extended-precision adder: one nibble per cycle through a single 4-bit adder, done NIBBLES cycles after start.
// start is honoured only while ready=1; requests at other times are dropped, never queued.
module suma_multinibble
  import suma_multinibble_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int OPW     = NIB_W * NIBBLES
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [OPW-1:0] A,
  input  logic [OPW-1:0] B,
  input  logic           cin,
  output logic           ready,
  output logic           done,
  output logic [OPW-1:0] S,
  output logic           cout,
  output logic           ovf
);

  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);

  state_t           r_state;
  logic [OPW-1:0]   r_a;
  logic [OPW-1:0]   r_b;
  logic [OPW-1:0]   r_work;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic             r_ready;
  logic             r_done;
  logic [OPW-1:0]   r_s;
  logic             r_cout;
  logic             r_ovf;

  logic [NIB_W-1:0] w_x;
  logic [NIB_W-1:0] w_y;
  logic [NIB_W:0]   w_sum;
  logic [OPW-1:0]   w_merged;
  logic             w_ovf;

  assign w_x = r_a[{r_idx, 2'b00} +: NIB_W];
  assign w_y = r_b[{r_idx, 2'b00} +: NIB_W];

  S4bits_instanciado u_add4 (
    .X   (w_x),
    .Y   (w_y),
    .cin (r_carry),
    .W   (w_sum)
  );

  // Work register with the current nibble already folded in, so the last
  // SUMA edge can publish the complete sum without an extra cycle.
  always_comb begin
    w_merged = r_work;
    w_merged[{r_idx, 2'b00} +: NIB_W] = w_sum[NIB_W-1:0];
  end

  assign w_ovf = (r_a[OPW-1] == r_b[OPW-1]) && (w_merged[OPW-1] != r_a[OPW-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= cin;
            r_work  <= '0;
            r_idx   <= '0;
            r_ready <= 1'b0;
            r_state <= SUMA;
          end
        end
        SUMA: begin
          r_work  <= w_merged;
          r_carry <= w_sum[NIB_W];
          if (r_idx == IDX_LAST) begin
            r_s     <= w_merged;
            r_cout  <= w_sum[NIB_W];
            r_ovf   <= w_ovf;
            r_done  <= 1'b1;
            r_state <= FIN;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign done  = r_done;
  assign S     = r_s;
  assign cout  = r_cout;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_suma_multinibble.sv
// Directed bench for the 16-bit (4-nibble) configuration of suma_multinibble.
module tb_suma_multinibble;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        cin;
  logic        ready;
  logic        done;
  logic [15:0] S;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  suma_multinibble #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .cin   (cin),
    .ready (ready),
    .done  (done),
    .S     (S),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one addition from IDLE and check latency, result and return to idle.
  task automatic add_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [15:0] exp_s, input logic exp_c,
                        input logic exp_o);
    int lat;
    A = a;
    B = b;
    cin = c;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check({tag, " latency"}, lat, 4);
    check({tag, " S"}, {16'h0, S}, {16'h0, exp_s});
    check({tag, " cout"}, {31'h0, cout}, {31'h0, exp_c});
    check({tag, " ovf"}, {31'h0, ovf}, {31'h0, exp_o});
    check({tag, " ready in FIN"}, {31'h0, ready}, 32'h0);
    step();
    check({tag, " ready after"}, {31'h0, ready}, 32'h1);
    check({tag, " done after"}, {31'h0, done}, 32'h0);
  endtask

  task automatic count_dones(input string tag, input int cycles);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (done === 1'b1) n++;
    end
    check({tag, " spurious done"}, n, 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    A     = 16'h0;
    B     = 16'h0;
    cin   = 1'b0;
    step();
    step();
    check("reset ready", {31'h0, ready}, 32'h1);
    check("reset done", {31'h0, done}, 32'h0);
    check("reset S", {16'h0, S}, 32'h0);
    check("reset cout", {31'h0, cout}, 32'h0);
    check("reset ovf", {31'h0, ovf}, 32'h0);
    rst = 1'b0;
    step();

    add_op("basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    add_op("nibcarry",16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0);
    add_op("ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    add_op("posovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    add_op("negovf",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    add_op("cin",     16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Starts during SUMA and during FIN must be ignored.
    A = 16'h1111;
    B = 16'h1111;
    cin = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    A = 16'hAAAA;
    B = 16'h5555;
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy done c3", {31'h0, done}, 32'h0);
    step();
    check("busy done c4", {31'h0, done}, 32'h0);
    step();
    check("busy done", {31'h0, done}, 32'h1);
    check("busy S", {16'h0, S}, 32'h2222);
    start = 1'b1;
    step();
    start = 1'b0;
    check("fin start ready", {31'h0, ready}, 32'h1);
    check("fin start done", {31'h0, done}, 32'h0);
    check("fin start S held", {16'h0, S}, 32'h2222);
    count_dones("ignored starts", 6);
    add_op("after busy", 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0);

    // Reset in the middle of SUMA discards the partial result.
    A = 16'hFFFF;
    B = 16'h0001;
    cin = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst ready", {31'h0, ready}, 32'h1);
    check("midrst done", {31'h0, done}, 32'h0);
    check("midrst S", {16'h0, S}, 32'h0);
    check("midrst cout", {31'h0, cout}, 32'h0);
    check("midrst ovf", {31'h0, ovf}, 32'h0);
    count_dones("midrst", 6);
    add_op("post rst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
